mdu_ctrl: RTL
=============

# mdu_ctrl

Multiply/divide sequencer for the five-stage MIPS pipeline, sitting beside the ALU in the E stage. It accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers. It models fixed multi-cycle latency with a down-counter and drives the stall request that holds a multiply/divide-class instruction in D while the unit is occupied. The hazard stall unit ORs `md_stall` into its global stall.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu.
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: E-stage instruction is valid and issues to the MDU this cycle.
- `op` in 4: E-stage MDU opcode (encoding in package).
- `rs_data` in 32: forwarded rs operand from E.
- `rt_data` in 32: forwarded rt operand from E.
- `d_is_md` in 1: D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy` out 1: a mult/div is in flight.
- `md_stall` out 1: stall request for D.
- `hi_out` out 32: current HI register (read by mfhi in E).
- `lo_out` out 32: current LO register (read by mflo in E).

## Operation
- Two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; counter `cnt` counts remaining cycles.
- IDLE, `start` with op MULT/MULTU/DIV/DIVU:
  - Compute the result from `rs_data`/`rt_data` in that cycle and latch it into `hi_tmp`/`lo_tmp`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES; go to RUN.
- MULT is a signed 32x32→64 multiply; MULTU is unsigned. HI = product[63:32], LO = product[31:0].
- DIV/DIVU: LO = quotient, HI = remainder. DIV is signed, truncating toward zero; the remainder takes the dividend's sign.
- Divide by zero (`rt_data`==0): the full DIV_CYCLES latency still elapses; HI/LO keep their prior values.
- RUN: `cnt` decrements each cycle. In the cycle where `cnt`==1, commit `hi_tmp`/`lo_tmp` to HI/LO at the edge and return to IDLE.
- IDLE, `start` with MTHI/MTLO: write `rs_data` to HI/LO at that edge. No state change.
- MFHI/MFLO/NONE: no state effect.
- `md_stall` = `d_is_md` & (`busy` | (`start` & op ∈ {MULT, MULTU, DIV, DIVU})).
- `start` while in RUN is a protocol violation, guaranteed not to occur by `md_stall`. It is ignored and flagged by a simulation assertion.

## Timing
- Reset values: state=IDLE, `cnt`=0, HI=LO=0, `hi_tmp`=`lo_tmp`=0, `busy`=0, `md_stall`=0.
- A start sampled at edge E0 gives:
  - `busy`=1 for the cycles after E0 through E_N, where N is the latency.
  - HI/LO take the new values at edge E_N, so `hi_out`/`lo_out` reflect them from that cycle on.
  - `busy` falls at the same edge.
- `md_stall` is combinational. It is asserted in the start cycle itself (when `d_is_md`) and for all N busy cycles.
- Back-to-back ops: a second mult/div can start in the first cycle `busy`=0.
- MTHI/MTLO latency is 1 edge. `hi_out`/`lo_out` are pure register outputs with no bypass of same-cycle writes.
- `reset` in RUN aborts the operation at the next edge. No commit, and all registers return to reset values.

## Structure
- Shared package `mdu_pkg` holds:
  - The opcode encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - The state encoding (IDLE=0, RUN=1).
  - A `is_md_calc(op)` helper function.
- Natural sub-module: `mdu_calc`. It is a combinational 64-bit result generator (op, a, b → hi, lo, div0 flag), isolated so a true iterative divider can replace it later.
- The counter width is ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).

## Test plan
- After reset: MULT with rs=0xFFFFFFFF, rt=2.
  - `busy` is high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU rs=7, rt=2 → LO=3, HI=1.
- Hazard sequence:
  - With `d_is_md`=1 during a DIV start, `md_stall`=1 in the start cycle plus 10 more cycles.
  - With `d_is_md`=0, `md_stall` stays 0 while `busy`=1.
- Setup: MTHI 0x12345678 then MTLO 0xCAFEBABE, giving HI/LO=0x12345678/0xCAFEBABE.
  - DIV by 0 then leaves HI/LO unchanged after 10 busy cycles.
  - MFHI in any cycle returns `hi_out`.
- Reset mid-op: assert `reset` 3 cycles into MULT 3×4.
  - Next cycle: `busy`=0 and HI=LO=0.
  - No commit of 12 occurs afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   - MDU opcode encoding driven by the E stage
//   - sequencer state encoding
//   - is_md_calc(): true for the long-latency arithmetic ops
package mdu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic is_md_calc(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit result generator for mult/multu/div/divu.
// Kept separate so an iterative divider can replace it later.
// Ports:
//   op    in  4  : MDU opcode
//   a     in  32 : rs operand (multiplicand / dividend)
//   b     in  32 : rt operand (multiplier / divisor)
//   hi    out 32 : product[63:32] or remainder
//   lo    out 32 : product[31:0] or quotient
//   div0  out 1  : divide op with a zero divisor (result must not be committed)
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic            div0
);

  logic signed [63:0] s_prod;
  logic [63:0]        u_prod;
  logic [31:0]        abs_a;
  logic [31:0]        abs_b;
  logic [31:0]        mag_q;
  logic [31:0]        mag_r;
  logic [31:0]        s_q;
  logic [31:0]        s_r;
  logic [31:0]        u_q;
  logic [31:0]        u_r;
  logic               b_zero;

  assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign u_prod = {32'h0, a} * {32'h0, b};

  assign b_zero = (b == 32'h0);

  // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no
  // special case: the magnitude 0x80000000 negates back to itself.
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;
  assign mag_q = b_zero ? 32'h0 : (abs_a / abs_b);
  assign mag_r = b_zero ? 32'h0 : (abs_a % abs_b);
  assign s_q   = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign s_r   = a[31] ? (~mag_r + 32'd1) : mag_r;

  assign u_q = b_zero ? 32'h0 : (a / b);
  assign u_r = b_zero ? 32'h0 : (a % b);

  assign div0 = is_md_div(op) && b_zero;

  always_comb begin
    hi = 32'h0;
    lo = 32'h0;
    case (op)
      OP_MULT: begin
        hi = s_prod[63:32];
        lo = s_prod[31:0];
      end
      OP_MULTU: begin
        hi = u_prod[63:32];
        lo = u_prod[31:0];
      end
      OP_DIV: begin
        hi = s_r;
        lo = s_q;
      end
      OP_DIVU: begin
        hi = u_r;
        lo = u_q;
      end
      default: begin
        hi = 32'h0;
        lo = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer beside the E-stage ALU. Owns HI/LO,
// models fixed mult/div latency with a down-counter and requests a D-stage
// stall while the unit is occupied.
// Ports:
//   clk      in  1  : pipeline clock
//   reset    in  1  : synchronous, active-high
//   start    in  1  : E-stage MDU instruction issues this cycle
//   op       in  4  : E-stage MDU opcode
//   rs_data  in  32 : forwarded rs operand
//   rt_data  in  32 : forwarded rt operand
//   d_is_md  in  1  : D-stage instruction is an MDU instruction
//   busy     out 1  : mult/div in flight
//   md_stall out 1  : stall request for D (combinational)
//   hi_out   out 32 : HI register
//   lo_out   out 32 : LO register
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no op in flight; accepts mult/div and mthi/mtlo
// RUN   | op in flight; cnt = remaining cycles, commit when cnt reaches 1
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs_data,
  input  logic [31:0]     rt_data,
  input  logic            d_is_md,
  output logic            busy,
  output logic            md_stall,
  output logic [31:0]     hi_out,
  output logic [31:0]     lo_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [31:0]      hi_tmp;
  logic [31:0]      lo_tmp;
  logic             tmp_div0;

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_div0;
  logic             calc_start;

  mdu_calc u_calc (
    .op   (op),
    .a    (rs_data),
    .b    (rt_data),
    .hi   (calc_hi),
    .lo   (calc_lo),
    .div0 (calc_div0)
  );

  assign calc_start = start && is_md_calc(op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi_reg   <= 32'h0;
      lo_reg   <= 32'h0;
      hi_tmp   <= 32'h0;
      lo_tmp   <= 32'h0;
      tmp_div0 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (calc_start) begin
            hi_tmp   <= calc_hi;
            lo_tmp   <= calc_lo;
            tmp_div0 <= calc_div0;
            cnt      <= is_md_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state    <= ST_RUN;
          end else if (start && (op == OP_MTHI)) begin
            hi_reg <= rs_data;
          end else if (start && (op == OP_MTLO)) begin
            lo_reg <= rs_data;
          end
        end
        ST_RUN: begin
          if (cnt == CNT_W'(1)) begin
            // Divide by zero burns the full latency but leaves HI/LO alone.
            if (!tmp_div0) begin
              hi_reg <= hi_tmp;
              lo_reg <= lo_tmp;
            end
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == ST_RUN);
  assign md_stall = d_is_md && (busy || calc_start);
  assign hi_out   = hi_reg;
  assign lo_out   = lo_reg;

  // md_stall keeps new MDU instructions out of E while busy; a start here
  // means the hazard logic upstream is broken. The request is dropped.
  a_no_start_in_run: assert property (@(posedge clk) disable iff (reset) !(busy && start))
    else $error("mdu_ctrl: start while busy");

endmodule
